// File: rtl/obstacle_sequencer_if.sv
// Bus between game control, the obstacle generators, the display pipeline and the sequencer.
// The master side drives control, done pulses, channel data and timing; the slave side is the sequencer.
interface obstacle_sequencer_if #(
    parameter int unsigned NUM_OBS = 8,
    parameter int unsigned CODE_W  = 4,
    parameter int unsigned DATA_W  = 36,
    parameter int unsigned TIM_W   = 28,
    parameter int unsigned CNT_W   = 16
);
    logic                      play_selected;
    logic                      victory;
    logic                      game_on;
    logic                      random_mode;
    logic [NUM_OBS-1:0]        enable_mask;
    logic [NUM_OBS-1:0]        obs_done;
    logic [NUM_OBS*DATA_W-1:0] obs_data;
    logic [TIM_W-1:0]          timing_in;
    logic [NUM_OBS-1:0]        obs_start;
    logic [CODE_W-1:0]         selected_obstacle;
    logic                      active;
    logic [DATA_W-1:0]         obstacle_data;
    logic [TIM_W-1:0]          delayed_signals;
    logic [CNT_W-1:0]          obstacles_counted;
    logic                      timeout_err;

    modport master (
        output play_selected, victory, game_on, random_mode, enable_mask,
               obs_done, obs_data, timing_in,
        input  obs_start, selected_obstacle, active, obstacle_data,
               delayed_signals, obstacles_counted, timeout_err
    );

    modport slave (
        input  play_selected, victory, game_on, random_mode, enable_mask,
               obs_done, obs_data, timing_in,
        output obs_start, selected_obstacle, active, obstacle_data,
               delayed_signals, obstacles_counted, timeout_err
    );
endinterface

// File: rtl/obstacle_sequencer.sv
// Obstacle scheduler: picks the next channel (round-robin or LFSR), sequences start/done/timeout
// with an inter-obstacle gap, counts completions and muxes the running channel's data.
module obstacle_sequencer #(
    parameter int unsigned NUM_OBS     = 8,
    parameter int unsigned CODE_W      = 4,
    parameter int unsigned DATA_W      = 36,
    parameter int unsigned TIM_W       = 28,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned GAP_CYCLES  = 60,
    parameter int unsigned OBS_TIMEOUT = 0,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input logic                 clk,
    input logic                 rst,
    obstacle_sequencer_if.slave bus
);
    localparam int unsigned IDX_W       = (NUM_OBS > 1) ? $clog2(NUM_OBS) : 1;
    localparam int unsigned RUN_W       = $clog2(OBS_TIMEOUT + 2);
    localparam int unsigned GAP_W       = $clog2(GAP_CYCLES + 2);
    localparam int unsigned REJ_W       = 5;
    localparam int unsigned MAX_REJECTS = 16;

    typedef enum logic [1:0] {IDLE, PICK, RUN, GAP} state_t;

    state_t             state;
    logic [7:0]         lfsr;
    logic               first_pick;
    logic [REJ_W-1:0]   rejects;
    logic [RUN_W-1:0]   run_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [NUM_OBS-1:0] start_q;
    logic [CODE_W-1:0]  sel_q;
    logic               active_q;
    logic               err_q;
    logic [DATA_W-1:0]  data_q;
    logic [TIM_W-1:0]   dly_q;
    logic [CNT_W-1:0]   count_q;

    logic [7:0]         lfsr_next;
    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W-1:0]   rr_idx;
    logic [IDX_W-1:0]   rr_pick;
    logic               rr_found;
    logic [CODE_W-1:0]  cand;
    logic               cand_ok;
    logic               pick_go;
    logic [IDX_W-1:0]   pick_idx;
    logic [DATA_W-1:0]  sel_data;

    // Fibonacci LFSR, polynomial x^8 + x^6 + x^5 + x^4 + 1
    assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    assign sel_idx   = IDX_W'(sel_q);
    assign cand      = CODE_W'(lfsr);

    // Round-robin: first enabled channel after the last pick; the very first search starts at 0
    always_comb begin
        rr_idx   = first_pick ? IDX_W'(NUM_OBS - 1) : sel_idx;
        rr_pick  = '0;
        rr_found = 1'b0;
        for (int i = 0; i < NUM_OBS; i++) begin
            rr_idx = (rr_idx == IDX_W'(NUM_OBS - 1)) ? '0 : rr_idx + 1'b1;
            if (!rr_found && bus.enable_mask[rr_idx]) begin
                rr_found = 1'b1;
                rr_pick  = rr_idx;
            end
        end
    end

    // Random candidate is rejected if out of range, disabled, or a repeat while alternatives exist
    always_comb begin
        cand_ok = 1'b0;
        if (32'(cand) < NUM_OBS) begin
            cand_ok = bus.enable_mask[IDX_W'(cand)] &&
                      (first_pick || cand != sel_q || $onehot(bus.enable_mask));
        end
    end

    always_comb begin
        pick_go  = 1'b0;
        pick_idx = rr_pick;
        if (rr_found) begin
            if (!bus.random_mode || 32'(rejects) == MAX_REJECTS) begin
                pick_go = 1'b1;
            end else if (cand_ok) begin
                pick_go  = 1'b1;
                pick_idx = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_OBS; k++) begin
            if (sel_q == CODE_W'(k)) sel_data = bus.obs_data[k*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lfsr       <= LFSR_SEED;
            first_pick <= 1'b1;
            rejects    <= '0;
            run_cnt    <= '0;
            gap_cnt    <= '0;
            start_q    <= '0;
            sel_q      <= '0;
            active_q   <= 1'b0;
            err_q      <= 1'b0;
            data_q     <= '0;
            dly_q      <= '0;
            count_q    <= '0;
        end else begin
            start_q <= '0;
            dly_q   <= bus.timing_in;
            data_q  <= active_q ? sel_data : '0;
            if (state == PICK && bus.random_mode) lfsr <= lfsr_next;

            // Restart outranks abort, which outranks a completion in the same cycle
            if (bus.play_selected) begin
                state    <= PICK;
                count_q  <= '0;
                err_q    <= 1'b0;
                active_q <= 1'b0;
                rejects  <= '0;
            end else if (bus.victory && state != IDLE) begin
                state    <= IDLE;
                active_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: ;
                    PICK: begin
                        if (pick_go) begin
                            state      <= RUN;
                            sel_q      <= CODE_W'(pick_idx);
                            start_q    <= NUM_OBS'(1) << pick_idx;
                            active_q   <= 1'b1;
                            first_pick <= 1'b0;
                            rejects    <= '0;
                            run_cnt    <= '0;
                        end else if (rr_found) begin
                            rejects <= rejects + 1'b1;
                        end
                    end
                    RUN: begin
                        if (bus.obs_done[sel_idx] ||
                            (OBS_TIMEOUT != 0 && bus.game_on && run_cnt == RUN_W'(OBS_TIMEOUT))) begin
                            if (bus.obs_done[sel_idx]) begin
                                if (~&count_q) count_q <= count_q + 1'b1;
                            end else begin
                                err_q <= 1'b1;
                            end
                            active_q <= 1'b0;
                            gap_cnt  <= '0;
                            state    <= (GAP_CYCLES == 0) ? PICK : GAP;
                        end else if (bus.game_on) begin
                            run_cnt <= run_cnt + 1'b1;
                        end
                    end
                    GAP: begin
                        if (bus.game_on) begin
                            if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) state <= PICK;
                            else gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.obs_start         = start_q;
    assign bus.selected_obstacle = sel_q;
    assign bus.active            = active_q;
    assign bus.obstacle_data     = data_q;
    assign bus.delayed_signals   = dly_q;
    assign bus.obstacles_counted = count_q;
    assign bus.timeout_err       = err_q;
endmodule

// File: doc/obstacle_sequencer.md
# obstacle_sequencer

Parametrised obstacle scheduler for the game datapath, sitting between the per-obstacle generators and the display pipeline. Chooses which of NUM_OBS obstacle channels runs next (round-robin or LFSR-random over an enable mask), issues a one-cycle start pulse, and waits for that channel's done pulse or a timeout. Inserts a programmable gap between obstacles and counts completed obstacles. Drives a registered data mux with the raster timing signals delayed to match.

## Interface
- NUM_OBS, 8, number of obstacle channels (2..16)
- CODE_W, 4, width of selected_obstacle (≥ clog2(NUM_OBS))
- DATA_W, 36, per-channel data width ({x[11:0], y[11:0], rgb[11:0]})
- TIM_W, 28, width of raster timing bundle
- CNT_W, 16, width of obstacles_counted
- GAP_CYCLES, 60, idle cycles between obstacles (0 = back-to-back)
- OBS_TIMEOUT, 0, max RUN cycles per obstacle (0 = timeout disabled)
- LFSR_SEED, 8'hA5, non-zero reset value of the 8-bit LFSR
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- play_selected  input  1  start/restart pulse
- victory  input  1  abort sequence, return to IDLE
- game_on  input  1  high = run; low = pause timers
- random_mode  input  1  0 = round-robin, 1 = LFSR pick
- enable_mask  input  NUM_OBS  channels eligible for selection
- obs_done  input  NUM_OBS  per-channel done pulses
- obs_data  input  NUM_OBS*DATA_W  packed channel data, channel k at [k*DATA_W +: DATA_W]
- timing_in  input  TIM_W  {vcount, vsync, vblnk, hcount, hsync, hblnk}
- obs_start  output  NUM_OBS  one-hot, one-cycle start pulse
- selected_obstacle  output  CODE_W  index of current/last channel
- active  output  1  high while a channel is in RUN
- obstacle_data  output  DATA_W  registered mux output
- delayed_signals  output  TIM_W  timing_in delayed 1 cycle
- obstacles_counted  output  CNT_W  completed obstacles, saturating
- timeout_err  output  1  sticky, set on any timeout

## Operation
- States: IDLE, PICK, RUN, GAP.
- IDLE: wait for play_selected; on it clear obstacles_counted and timeout_err, go PICK.
- PICK: enable_mask == 0 → stay in PICK, no start. Round-robin: first enabled index after selected_obstacle (wrapping modulo NUM_OBS; first pick after reset starts search at 0). Random: candidate = lfsr[CODE_W-1:0]; accept if < NUM_OBS, enabled, and ≠ previous pick (repeat allowed only when exactly one bit of enable_mask set); otherwise step LFSR and retry next cycle; after 16 rejected candidates, fall back to the round-robin choice. On accept: selected_obstacle ← k, obs_start[k] = 1 for one cycle, go RUN.
- RUN: obs_done[selected] → count += 1 (saturate at all-ones), go GAP. obs_done on other channels ignored. Timeout reached → timeout_err = 1, no count, go GAP.
- GAP: hold GAP_CYCLES cycles, then PICK; GAP_CYCLES = 0 → directly PICK.
- victory (any state except IDLE) → IDLE; count retained; no start issued. victory beats obs_done in same cycle.
- play_selected in PICK/RUN/GAP → restart: clear count and timeout_err, go PICK. play_selected beats obs_done and victory in same cycle.
- game_on low: RUN timeout counter and GAP counter frozen; obs_done still honoured.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, steps every cycle while in PICK and random_mode = 1.
- obstacle_data register: obs_data[selected] when active, else 0.

## Timing
- Reset values: state IDLE, obs_start 0, selected_obstacle 0, active 0, obstacle_data 0, delayed_signals 0, obstacles_counted 0, timeout_err 0, lfsr LFSR_SEED.
- play_selected sampled at cycle T → PICK at T+1 → (round-robin) obs_start and new selected_obstacle, active high, registered at T+2.
- obs_done sampled at D → count updates and active low at D+1; next obs_start at D+1+GAP_CYCLES+1.
- Timeout: obs_start at S → timeout_err and active low at S+OBS_TIMEOUT+1 (game_on held high).
- obstacle_data and delayed_signals: exactly 1 cycle latency, mutually aligned.

## Test plan
- NUM_OBS=8, GAP_CYCLES=4, mask 8'hFF, round-robin, play_selected, each channel done 10 cycles after start → starts on channels 0,1,…,7,0; count=8 after eighth done; gaps exactly 4 cycles.
- Mask 8'b1010_0100, random_mode=1, 200 obstacles → only channels 2,5,7 started, no two consecutive equal, every start one-hot and one cycle.
- OBS_TIMEOUT=20, channel never asserts done → timeout_err=1 at S+21, count unchanged, next channel started after gap.
- victory during RUN with count=3 → active=0 next cycle, count stays 3; play_selected then clears count to 0 and restarts.
- obs_done on non-selected channel, and mask=0 in PICK → no count change, no start; set mask=1 → start on channel 0.
- obs_data pattern per channel, random timing_in → obstacle_data = selected channel's data and delayed_signals = timing_in, both 1 cycle late; obstacle_data = 0 when inactive.
